// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared EX/MEM defines: state encoding, access lengths, extension helper
package mem_stage_pkg;

    localparam int EX_DATA_W    = 32;
    localparam int EX_REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } mem_state_e;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // Any length code other than byte/half is a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        logic [2:0] r;
        case (len)
            LEN_BYTE: r = LEN_BYTE;
            LEN_HALF: r = LEN_HALF;
            default:  r = LEN_WORD;
        endcase
        return r;
    endfunction

    function automatic logic [EX_DATA_W-1:0] sign_extend(input logic [EX_DATA_W-1:0] raw,
                                                         input logic [2:0]           len,
                                                         input logic                 is_signed);
        logic [EX_DATA_W-1:0] r;
        case (norm_len(len))
            LEN_BYTE: r = {{24{is_signed & raw[7]}}, raw[7:0]};
            LEN_HALF: r = {{16{is_signed & raw[15]}}, raw[15:0]};
            default:  r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_extend.sv
// rtl/mem_extend.sv - sign/zero extension of an assembled load value
module mem_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  len,
    input  logic        is_signed,
    output logic [31:0] result
);

    assign result = sign_extend(raw, len, is_signed);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - byte-serial load/store memory stage; MEM_MISALIGN_TRAP_EN adds misalign trap
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        save,
    input  logic [31:0] sl_reg_address,
    input  logic [31:0] sl_data,
    input  logic [2:0]  sl_data_length,
    input  logic        sl_data_signed,
    input  logic        modify_flag,
    input  logic [31:0] modify_address,
    input  logic [31:0] modify_data,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic        stall_req,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        wb_flag,
    output logic [4:0]  wb_address,
    output logic [31:0] wb_data
);

    mem_state_e  state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic        sgn_q, sgn_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic [31:0] asm_q, asm_d;
    logic        wb_flag_q, wb_flag_d;
    logic [4:0]  wb_address_q, wb_address_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [2:0]  req_len;
    logic        trap;
    logic [31:0] asm_fill;
    logic [31:0] ext_result;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^modify_address[31:5];
    assign req_len          = norm_len(sl_data_length);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = ((req_len == LEN_HALF) && sl_reg_address[0]) ||
                  ((req_len == LEN_WORD) && (sl_reg_address[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Byte arriving this cycle merged into the little-endian assembly word.
    always_comb begin
        asm_fill = asm_q;
        asm_fill[{k_q[1:0], 3'b000} +: 8] = mem_din;
    end

    mem_extend u_extend (
        .raw       (asm_fill),
        .len       (len_q),
        .is_signed (sgn_q),
        .result    (ext_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            base_q       <= '0;
            len_q        <= LEN_WORD;
            sgn_q        <= 1'b0;
            dest_q       <= '0;
            data_q       <= '0;
            asm_q        <= '0;
            wb_flag_q    <= 1'b0;
            wb_address_q <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            base_q       <= base_d;
            len_q        <= len_d;
            sgn_q        <= sgn_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
            asm_q        <= asm_d;
            wb_flag_q    <= wb_flag_d;
            wb_address_q <= wb_address_d;
            wb_data_q    <= wb_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        len_d        = len_q;
        sgn_d        = sgn_q;
        dest_d       = dest_q;
        data_d       = data_q;
        asm_d        = asm_q;
        wb_flag_d    = wb_flag_q;
        wb_address_d = wb_address_q;
        wb_data_d    = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (load || save) begin
                    wb_flag_d = 1'b0;
                    base_d    = sl_reg_address;
                    len_d     = req_len;
                    sgn_d     = sl_data_signed;
                    dest_d    = modify_address[4:0];
                    data_d    = sl_data;
                    asm_d     = '0;
                    if (trap) begin
                        state_d = ST_DONE;
                    end else if (load) begin
                        k_d     = 3'd0;
                        state_d = ST_LOAD;
                    end else begin
                        // Byte 0 is written this cycle, STORE continues from byte 1.
                        k_d     = 3'd1;
                        state_d = (req_len == LEN_BYTE) ? ST_DONE : ST_STORE;
                    end
                end else begin
                    wb_flag_d    = modify_flag;
                    wb_address_d = modify_address[4:0];
                    wb_data_d    = modify_data;
                end
            end
            ST_LOAD: begin
                asm_d = asm_fill;
                if (k_q == len_q - 3'd1) begin
                    state_d      = ST_DONE;
                    wb_flag_d    = 1'b1;
                    wb_address_d = dest_q;
                    wb_data_d    = ext_result;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_STORE: begin
                if (k_q == len_q - 3'd1) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_DONE: begin
                // Result was presented for exactly this cycle; don't repeat the writeback.
                state_d   = ST_IDLE;
                wb_flag_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_a     = '0;
        mem_dout  = '0;
        mem_wr    = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load || save) begin
                    stall_req = 1'b1;
                    if (!trap) begin
                        mem_a = sl_reg_address;
                        if (!load) begin
                            mem_dout = sl_data[7:0];
                            mem_wr   = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: begin
                stall_req = 1'b1;
                if (k_q != len_q - 3'd1) begin
                    mem_a = base_q + {29'd0, k_q} + 32'd1;
                end
            end
            ST_STORE: begin
                stall_req = 1'b1;
                mem_a     = base_q + {29'd0, k_q};
                mem_dout  = data_q[{k_q[1:0], 3'b000} +: 8];
                mem_wr    = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            mem_a    = '0;
            mem_dout = '0;
            mem_wr   = 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = (state_q == ST_IDLE) && (load || save) && trap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`endif

    assign wb_flag    = wb_flag_q;
    assign wb_address = wb_address_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with byte-addressed RAM model
module tb_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, save, sl_data_signed, modify_flag;
    logic [31:0] sl_reg_address, sl_data, modify_address, modify_data;
    logic [2:0]  sl_data_length;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'h00;
    logic        mem_wr, stall_req, wb_flag;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .save           (save),
        .sl_reg_address (sl_reg_address),
        .sl_data        (sl_data),
        .sl_data_length (sl_data_length),
        .sl_data_signed (sl_data_signed),
        .modify_flag    (modify_flag),
        .modify_address (modify_address),
        .modify_data    (modify_data),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .stall_req      (stall_req),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign       (misalign),
`endif
        .wb_flag        (wb_flag),
        .wb_address     (wb_address),
        .wb_data        (wb_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    logic [7:0]  phys_ram [logic [31:0]];
    logic [7:0]  ref_ram  [logic [31:0]];
    logic [36:0] wb_q [$];
    logic [39:0] wr_q [$];
    logic [31:0] rd_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] phys_read(input logic [31:0] a);
        if (phys_ram.exists(a)) return phys_ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_ram.exists(a)) return ref_ram[a];
        return init_byte(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        phys_ram[a] = b;
        ref_ram[a]  = b;
    endtask

    // RAM: read data valid the cycle after the address.
    always @(posedge clk) mem_din <= phys_read(mem_a);
    always @(posedge clk) if (mem_wr) phys_ram[mem_a] = mem_dout;

    logic [39:0] we;
    logic [36:0] wbe;
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    check("unexpected mem_wr", {31'd0, mem_wr}, 32'd0);
                end else begin
                    we = wr_q.pop_front();
                    check("write addr", mem_a, we[39:8]);
                    check("write byte", {24'd0, mem_dout}, {24'd0, we[7:0]});
                end
            end else if (stall_req) begin
                if (rd_q.size() != 0) check("read addr", mem_a, rd_q.pop_front());
                else                  check("no-access addr", mem_a, 32'd0);
            end else begin
                check("idle addr", mem_a, 32'd0);
                check("idle dout", {24'd0, mem_dout}, 32'd0);
            end
            if (wb_flag) begin
                if (wb_q.size() == 0) begin
                    check("unexpected wb_flag", {31'd0, wb_flag}, 32'd0);
                end else begin
                    wbe = wb_q.pop_front();
                    check("wb_address", {27'd0, wb_address}, {27'd0, wbe[36:32]});
                    check("wb_data", wb_data, wbe[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] len, input logic sgn, input logic mf,
                         input logic [31:0] maddr, input logic [31:0] mdata);
        load = ld; save = st; sl_reg_address = addr; sl_data = data; sl_data_length = len;
        sl_data_signed = sgn; modify_flag = mf; modify_address = maddr; modify_data = mdata;
    endtask

    task automatic idle(input int cycles);
        drive(0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Issue one EX_MEM instruction, push its expected effects, hold it while stalled.
    task automatic issue(input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] len, input logic sgn, input logic mf,
                         input logic [31:0] maddr, input logic [31:0] mdata, output logic [31:0] wb_seen);
        int      n, stalls, exp_stalls;
        bit      trap, done;
        logic [31:0] raw;
        logic [7:0]  b;
        longint  v;
        n    = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        trap = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (ld || st) && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
`endif
        if (trap) begin
            exp_stalls = 1;
        end else if (ld) begin
            exp_stalls = n + 1;
            raw = 0;
            for (int i = 0; i < n; i++) begin
                rd_q.push_back(addr + 32'(i));
                raw = raw | (32'(ref_byte(addr + 32'(i))) << (8 * i));
            end
            v = longint'(raw);
            if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            wb_q.push_back({maddr[4:0], v[31:0]});
        end else if (st) begin
            exp_stalls = n;
            for (int i = 0; i < n; i++) begin
                b = 8'(data >> (8 * i));
                wr_q.push_back({addr + 32'(i), b});
                ref_ram[addr + 32'(i)] = b;
            end
        end else begin
            exp_stalls = 0;
            if (mf) wb_q.push_back({maddr[4:0], mdata});
        end
        drive(ld, st, addr, data, len, sgn, mf, maddr, mdata);
        stalls = 0;
        done   = 0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            else           done = 1;
        end
        check("stall cycles", done ? 32'(stalls) : 32'd99, 32'(exp_stalls));
        wb_seen = wb_data;
        if (ld && !trap)    check("wb_flag in done", {31'd0, wb_flag}, 32'd1);
        else if (st || trap) check("wb_flag after store", {31'd0, wb_flag}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        if (ld || st) check("misalign pulse", {31'd0, misalign}, {31'd0, trap});
`endif
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seen;
    logic [2:0]  len_tab [10];
    int          op;

    initial begin
        len_tab = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd5, 3'd7};
        rst = 1'b0;
        drive(1, 0, 32'h40, 0, 3'd4, 0, 1, 32'd9, 32'hDEAD);
        repeat (3) @(posedge clk);
        #1;
        check("reset wb_flag", {31'd0, wb_flag}, 32'd0);
        check("reset wb_address", {27'd0, wb_address}, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        drive(0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        rst = 1'b1;
        mon_en = 1;
        @(posedge clk);
        #1;

        issue(0, 0, 0, 0, 3'd1, 0, 1, 32'd5, 32'h1234, seen);
        check("alu wb_flag", {31'd0, wb_flag}, 32'd1);
        check("alu wb_address", {27'd0, wb_address}, 32'd5);
        check("alu wb_data", wb_data, 32'h1234);
        issue(0, 0, 0, 0, 3'd1, 0, 1, 32'hFFFF_FFE5, 32'hCAFE_0001, seen);
        issue(0, 0, 0, 0, 3'd1, 0, 0, 32'd3, 32'h5555, seen);

        preload(32'h100, 8'h80);
        issue(1, 0, 32'h100, 0, 3'd1, 1, 0, 32'd7, 0, seen);
        check("LB signed", seen, 32'hFFFF_FF80);
        issue(1, 0, 32'h100, 0, 3'd1, 0, 0, 32'd8, 0, seen);
        check("LBU", seen, 32'h0000_0080);

        preload(32'h200, 8'h78); preload(32'h201, 8'h56);
        preload(32'h202, 8'h34); preload(32'h203, 8'h12);
        issue(1, 0, 32'h200, 0, 3'd4, 1, 0, 32'd10, 0, seen);
        check("LW", seen, 32'h1234_5678);

        issue(0, 1, 32'h300, 32'h0000_BEEF, 3'd2, 0, 0, 0, 0, seen);
        issue(1, 0, 32'h300, 0, 3'd2, 1, 0, 32'd11, 0, seen);
        check("LH after SH", seen, 32'hFFFF_BEEF);

        issue(1, 0, 32'h102, 0, 3'd4, 0, 0, 32'd12, 0, seen);
        issue(1, 0, 32'hFFFF_FFFE, 0, 3'd2, 1, 0, 32'd13, 0, seen);
        issue(0, 1, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 3'd2, 0, 0, 0, 0, seen);
        issue(1, 0, 32'h200, 0, 3'd3, 0, 0, 32'd14, 0, seen);
        issue(1, 1, 32'h200, 32'h9999_9999, 3'd0, 0, 0, 32'd15, 0, seen);

        // Reset in the second cycle of a word store: only byte 0 lands.
        wr_q.push_back({32'h400, 8'hDD});
        ref_ram[32'h400] = 8'hDD;
        drive(0, 1, 32'h400, 32'hAABB_CCDD, 3'd4, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mem_wr under reset", {31'd0, mem_wr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        @(negedge clk);
        check("idle after reset stall", {31'd0, stall_req}, 32'd0);
        check("idle after reset wb_flag", {31'd0, wb_flag}, 32'd0);
        check("byte 2 unwritten", {24'd0, phys_read(32'h402)}, {24'd0, init_byte(32'h402)});
        @(posedge clk);
        #1;

        // Reset mid-load: partial data dropped, no writeback.
        rd_q.push_back(32'h200);
        drive(1, 0, 32'h200, 0, 3'd4, 0, 0, 32'd16, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);

        for (int t = 0; t < 300; t++) begin
            op = int'($urandom_range(0, 9));
            issue(op <= 3 || op == 7, op >= 4 && op <= 7,
                  ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 255)),
                  $urandom, len_tab[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, seen);
        end

        idle(4);
        check("wb queue drained", 32'(wb_q.size()), 32'd0);
        check("write queue drained", 32'(wr_q.size()), 32'd0);
        check("read queue drained", 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-low (rst==0 resets at clk edge).
REQ-002 SHALL have inputs from the EX_MEM register: load 1, save 1, sl_reg_address 32 (byte address), sl_data 32, sl_data_length 3 (1/2/4 bytes), sl_data_signed 1, modify_flag 1, modify_address 32 (destination register index; low 5 bits used), modify_data 32.
REQ-003 SHALL have RAM ports: mem_a out 32 (byte address), mem_dout out 8 (write byte), mem_wr out 1 (1=write), mem_din in 8 (read byte, valid the cycle after its address is driven).
REQ-004 SHALL have outputs: stall_req out 1 (holds EX_MEM and upstream stages), wb_flag out 1, wb_address out 5, wb_data out 32 (registered writeback to MEM_WB).
REQ-005 SHALL have output misalign out 1, present only when MEM_MISALIGN_TRAP_EN is defined.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, STORE, DONE.
REQ-007 In IDLE with load=save=0: SHALL register wb_flag<=modify_flag, wb_address<=modify_address[4:0], wb_data<=modify_data; 1-cycle latency; stall_req=0.
REQ-008 In IDLE with load=1: SHALL drive mem_a=sl_reg_address, mem_wr=0, latch address/length/signed/dest, set byte counter k=0, go LOAD; wb_flag<=0.
REQ-009 In LOAD: SHALL capture mem_din into byte k of a 32-bit assembly register (little-endian), drive mem_a=base+k+1 while k+1<length, increment k; after capturing byte length-1 go DONE.
REQ-010 On LOAD->DONE SHALL set wb_data to the assembled value, sign-extended from bit 8*length-1 if signed else zero-extended (length 4: unchanged); wb_flag<=1, wb_address<=latched dest.
REQ-011 In IDLE with save=1: SHALL drive mem_a=sl_reg_address, mem_dout=sl_data[7:0], mem_wr=1; latch data; go STORE if length>1 else DONE; wb_flag<=0.
REQ-012 In STORE: SHALL write byte k (sl_data[8k+7:8k]) to base+k each cycle with mem_wr=1; after byte length-1 go DONE.
REQ-013 stall_req SHALL be combinational: 1 in IDLE when load|save, 1 in LOAD and STORE, 0 in DONE and otherwise.
REQ-014 Latency: N-byte load SHALL assert stall_req N+1 cycles, wb_flag=1 the following (DONE) cycle; N-byte store SHALL stall N cycles, wb_flag=0.
REQ-015 In DONE SHALL ignore all EX_MEM inputs (still the completed op), drive mem_wr=0, return to IDLE next cycle; wb outputs hold one cycle then update in IDLE.
REQ-016 mem_wr SHALL be 0 in all states except write cycles of REQ-011/012; mem_a, mem_dout SHALL be 0 when idle with no access.
REQ-017 load and save simultaneously 1 SHALL be treated as load.
REQ-018 sl_data_length values other than 1/2/4 SHALL be treated as 4.
REQ-019 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).

Reset
REQ-020 rst==0 at a clk edge SHALL force IDLE, k=0, wb_flag=0, wb_address=0, wb_data=0, misalign=0; mem_wr SHALL be 0 while rst==0, including reset mid-store (remaining bytes abandoned).
REQ-021 Reset mid-load SHALL discard partial data; no wb_flag pulse follows.

Configuration
REQ-022 With MEM_MISALIGN_TRAP_EN defined: a load/save in IDLE with length 2 and address[0]!=0, or length 4 and address[1:0]!=0, SHALL perform no RAM access, go DONE directly, pulse misalign=1 in DONE, wb_flag=0.
REQ-023 Without MEM_MISALIGN_TRAP_EN: no misalign port; misaligned accesses proceed byte-wise normally.

Structure
REQ-024 State encoding, length encodings (1/2/4) and sign-extend helper SHALL live in the shared defines file alongside existing EX constants.
REQ-025 Sign/zero extension SHALL be a sub-module mem_extend (32-bit raw, length, signed -> 32-bit result); FSM stays in mem_stage.

Verification
REQ-026 ALU pass-through: modify_flag=1, addr=5, data=0x1234 -> next cycle wb_flag=1, wb_address=5, wb_data=0x1234, stall_req never 1.
REQ-027 LB signed at 0x100, RAM byte 0x80 -> stall 2 cycles, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-028 LW at 0x200, bytes 0x78,0x56,0x34,0x12 -> mem_a 0x200..0x203 in order, stall 5 cycles, wb_data=0x12345678.
REQ-029 SH 0xBEEF at 0x300 -> writes 0xEF@0x300, 0xBE@0x301, mem_wr high exactly 2 cycles, wb_flag=0.
REQ-030 Reset asserted during cycle 2 of SW -> mem_wr=0 from that edge, state IDLE, bytes 2-3 never written.
REQ-031 With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> no mem_wr/read address, misalign pulses 1 cycle; without macro -> reads 0x102..0x105.
